// File: rtl/complex_nr_mult_pipe_if.sv
// Operand/result handshake bundle for complex_nr_mult_pipe.
// The op_conj signal exists only when COMPLEX_CONJ_EN is defined.
interface complex_nr_mult_pipe_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 4
);
  localparam int unsigned RES_WIDTH = 2 * DATA_WIDTH + 1;
  localparam int unsigned CNT_WIDTH = $clog2(FIFO_DEPTH) + 1;

  logic                        op_val;
  logic                        op_ready;
  logic signed [DATA_WIDTH-1:0] op_1_re;
  logic signed [DATA_WIDTH-1:0] op_1_im;
  logic signed [DATA_WIDTH-1:0] op_2_re;
  logic signed [DATA_WIDTH-1:0] op_2_im;
`ifdef COMPLEX_CONJ_EN
  logic                        op_conj;
`endif
  logic                        res_val;
  logic                        res_ready;
  logic signed [RES_WIDTH-1:0] result_re;
  logic signed [RES_WIDTH-1:0] result_im;
  logic [CNT_WIDTH-1:0]        res_count;

  // Operand source and result consumer side
  modport master (
    output op_val, op_1_re, op_1_im, op_2_re, op_2_im,
`ifdef COMPLEX_CONJ_EN
    output op_conj,
`endif
    output res_ready,
    input  op_ready, res_val, result_re, result_im, res_count
  );

  // Multiplier side
  modport slave (
    input  op_val, op_1_re, op_1_im, op_2_re, op_2_im,
`ifdef COMPLEX_CONJ_EN
    input  op_conj,
`endif
    input  res_ready,
    output op_ready, res_val, result_re, result_im, res_count
  );
endinterface

// File: rtl/complex_nr_mult_pipe.sv
// Pipelined signed complex multiplier with a first-word-fall-through result
// FIFO and credit-based operand flow control.
// Optional feature macro: COMPLEX_CONJ_EN (per-operation op_1 * conj(op_2)).
module complex_nr_mult_pipe #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic                    clk,
  input logic                    sw_rst,
  complex_nr_mult_pipe_if.slave  bus
);
  localparam int unsigned RES_WIDTH    = 2 * DATA_WIDTH + 1;
  localparam int unsigned PROD_WIDTH   = 2 * DATA_WIDTH;
  localparam int unsigned PTR_WIDTH    = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_WIDTH    = PTR_WIDTH + 1;
  localparam int unsigned CREDIT_WIDTH = CNT_WIDTH + 1;

  logic s1_val, s2_val, s3_val;
  logic signed [DATA_WIDTH-1:0] s1_a, s1_b, s1_c, s1_d;
  logic signed [PROD_WIDTH-1:0] s2_ac, s2_bd, s2_ad, s2_bc;
  logic signed [RES_WIDTH-1:0]  s3_re, s3_im;
  logic signed [RES_WIDTH-1:0]  sum_re, sum_im;
`ifdef COMPLEX_CONJ_EN
  logic s1_conj, s2_conj;
`endif

  logic signed [RES_WIDTH-1:0] mem_re [FIFO_DEPTH];
  logic signed [RES_WIDTH-1:0] mem_im [FIFO_DEPTH];
  logic [PTR_WIDTH-1:0] wr_ptr, rd_ptr, wr_ptr_next, rd_ptr_next;
  logic [CNT_WIDTH-1:0] inflight, count, inflight_next, count_next;
  logic [CREDIT_WIDTH-1:0] credit_sum;

  logic op_ready_q, res_val_q, op_ready_next, res_val_next;
  logic signed [RES_WIDTH-1:0] result_re_q, result_im_q, head_re_next, head_im_next;
  logic accept, push, pop;

  assign bus.op_ready  = op_ready_q;
  assign bus.res_val   = res_val_q;
  assign bus.result_re = result_re_q;
  assign bus.result_im = result_im_q;
  assign bus.res_count = count;

  // Datapath stages; validity is tracked separately so no reset is needed here
  always_ff @(posedge clk) begin
    s1_a  <= bus.op_1_re;
    s1_b  <= bus.op_1_im;
    s1_c  <= bus.op_2_re;
    s1_d  <= bus.op_2_im;
    s2_ac <= PROD_WIDTH'(s1_a) * PROD_WIDTH'(s1_c);
    s2_bd <= PROD_WIDTH'(s1_b) * PROD_WIDTH'(s1_d);
    s2_ad <= PROD_WIDTH'(s1_a) * PROD_WIDTH'(s1_d);
    s2_bc <= PROD_WIDTH'(s1_b) * PROD_WIDTH'(s1_c);
    s3_re <= sum_re;
    s3_im <= sum_im;
`ifdef COMPLEX_CONJ_EN
    s1_conj <= bus.op_conj;
    s2_conj <= s1_conj;
`endif
  end

  // Stage 3 add/sub on sign-extended products; full precision
  always_comb begin
    sum_re = RES_WIDTH'(s2_ac) - RES_WIDTH'(s2_bd);
    sum_im = RES_WIDTH'(s2_ad) + RES_WIDTH'(s2_bc);
`ifdef COMPLEX_CONJ_EN
    if (s2_conj) begin
      sum_re = RES_WIDTH'(s2_ac) + RES_WIDTH'(s2_bd);
      sum_im = RES_WIDTH'(s2_bc) - RES_WIDTH'(s2_ad);
    end
`endif
  end

  // Result storage write port
  always_ff @(posedge clk) begin
    if (push) begin
      mem_re[wr_ptr] <= s3_re;
      mem_im[wr_ptr] <= s3_im;
    end
  end

  // Handshakes, credit accounting, pointers and the registered FIFO head
  always_comb begin
    accept        = bus.op_val & op_ready_q;
    push          = s3_val;
    pop           = res_val_q & bus.res_ready;
    inflight_next = inflight + CNT_WIDTH'(accept) - CNT_WIDTH'(push);
    count_next    = count + CNT_WIDTH'(push) - CNT_WIDTH'(pop);
    wr_ptr_next   = push ? wr_ptr + PTR_WIDTH'(1) : wr_ptr;
    rd_ptr_next   = pop ? rd_ptr + PTR_WIDTH'(1) : rd_ptr;
    credit_sum    = CREDIT_WIDTH'(inflight_next) + CREDIT_WIDTH'(count_next);
    op_ready_next = credit_sum < CREDIT_WIDTH'(FIFO_DEPTH);
    res_val_next  = count_next != '0;
    head_re_next  = result_re_q;
    head_im_next  = result_im_q;
    if (res_val_next) begin
      // The new head may be the entry being written at this very edge
      if (push && (rd_ptr_next == wr_ptr)) begin
        head_re_next = s3_re;
        head_im_next = s3_im;
      end else begin
        head_re_next = mem_re[rd_ptr_next];
        head_im_next = mem_im[rd_ptr_next];
      end
    end
  end

  // Control state with synchronous reset
  always_ff @(posedge clk) begin
    if (sw_rst) begin
      s1_val      <= 1'b0;
      s2_val      <= 1'b0;
      s3_val      <= 1'b0;
      inflight    <= '0;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      op_ready_q  <= 1'b0;
      res_val_q   <= 1'b0;
      result_re_q <= '0;
      result_im_q <= '0;
    end else begin
      s1_val      <= accept;
      s2_val      <= s1_val;
      s3_val      <= s2_val;
      inflight    <= inflight_next;
      count       <= count_next;
      wr_ptr      <= wr_ptr_next;
      rd_ptr      <= rd_ptr_next;
      op_ready_q  <= op_ready_next;
      res_val_q   <= res_val_next;
      result_re_q <= head_re_next;
      result_im_q <= head_im_next;
    end
  end
endmodule

// File: tb/tb_complex_nr_mult_pipe.sv
// Self-checking bench for complex_nr_mult_pipe with a result scoreboard.
// Conjugate scenarios run only when COMPLEX_CONJ_EN is defined.
module tb_complex_nr_mult_pipe;
  localparam int unsigned DW = 8;
  localparam int unsigned FD = 4;
  localparam int unsigned RW = 2 * DW + 1;

  typedef struct packed {
    logic signed [RW-1:0] re;
    logic signed [RW-1:0] im;
  } res_t;

  logic clk = 1'b0;
  logic sw_rst = 1'b1;
  int n_cmp = 0;
  int n_err = 0;
  int n_res = 0;
  res_t sb[$];

  complex_nr_mult_pipe_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(FD)) bus ();
  complex_nr_mult_pipe #(.DATA_WIDTH(DW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .sw_rst(sw_rst), .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference complex product
  function automatic res_t model(input int a, input int b, input int c, input int d, input bit conj);
    int re, im;
    res_t r;
    if (conj) begin
      re = a * c + b * d;
      im = b * c - a * d;
    end else begin
      re = a * c - b * d;
      im = a * d + b * c;
    end
    r.re = RW'(re);
    r.im = RW'(im);
    return r;
  endfunction

  // Scoreboard: push on accept, pop and compare on result handoff
  always @(negedge clk) begin
    res_t exp_r;
    if (sw_rst) begin
      sb.delete();
    end else begin
      if (bus.res_val && bus.res_ready) begin
        n_cmp++;
        n_res++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL sb_unexpected: got %0d %0dj, nothing expected", bus.result_re, bus.result_im);
        end else begin
          exp_r = sb.pop_front();
          if (bus.result_re !== exp_r.re || bus.result_im !== exp_r.im) begin
            n_err++;
            $display("FAIL sb_result: got %0d %0dj want %0d %0dj", bus.result_re, bus.result_im, exp_r.re, exp_r.im);
          end
        end
      end
      if (bus.op_val && bus.op_ready) begin
`ifdef COMPLEX_CONJ_EN
        sb.push_back(model(bus.op_1_re, bus.op_1_im, bus.op_2_re, bus.op_2_im, bus.op_conj));
`else
        sb.push_back(model(bus.op_1_re, bus.op_1_im, bus.op_2_re, bus.op_2_im, 1'b0));
`endif
      end
    end
  end

  task automatic set_op(input int a, input int b, input int c, input int d);
    bus.op_1_re = DW'(a);
    bus.op_1_im = DW'(b);
    bus.op_2_re = DW'(c);
    bus.op_2_im = DW'(d);
  endtask

  // Present one op and hold it until accepted; returns 1 time unit after the accept edge
  task automatic send_op(input int a, input int b, input int c, input int d, input bit rand_rdy);
    int tmo;
    set_op(a, b, c, d);
    bus.op_val = 1'b1;
    tmo = 0;
    @(negedge clk);
    while (!bus.op_ready && tmo < 50) begin
      @(posedge clk); #1;
      if (rand_rdy) bus.res_ready = 1'($urandom_range(1));
      @(negedge clk);
      tmo++;
    end
    if (tmo >= 50) begin
      n_cmp++; n_err++;
      $display("FAIL send_timeout: op_ready stuck at %b, want 1", bus.op_ready);
    end
    @(posedge clk); #1;
    bus.op_val = 1'b0;
    if (rand_rdy) bus.res_ready = 1'($urandom_range(1));
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    bus.res_ready = 1'b1;
    while ((sb.size() != 0 || bus.res_val || bus.res_count != 0) && t < 200) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (sb.size() != 0 || bus.res_count != 0) begin
      n_err++;
      $display("FAIL %s_drain: %0d pending, res_count %0d, want 0", name, sb.size(), bus.res_count);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    sw_rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (bus.op_ready !== 1'b0) begin n_err++; $display("FAIL reset_op_ready: got %b want 0", bus.op_ready); end
    n_cmp++; if (bus.res_val !== 1'b0) begin n_err++; $display("FAIL reset_res_val: got %b want 0", bus.res_val); end
    n_cmp++; if (bus.res_count !== 0) begin n_err++; $display("FAIL reset_res_count: got %0d want 0", bus.res_count); end
    n_cmp++; if (bus.result_re !== 0 || bus.result_im !== 0) begin n_err++; $display("FAIL reset_result: got %0d %0dj want 0 0j", bus.result_re, bus.result_im); end
    @(posedge clk); #1;
    sw_rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.op_ready !== 1'b0) begin n_err++; $display("FAIL reset_hold_op_ready: got %b want 0", bus.op_ready); end
    @(negedge clk);
    n_cmp++; if (bus.op_ready !== 1'b1) begin n_err++; $display("FAIL reset_release_op_ready: got %b want 1", bus.op_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    bus.res_ready = 1'b1;
    send_op(3, 4, 5, -2, 1'b0);
    for (int m = 0; m < 4; m++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.res_val !== (m == 3)) begin n_err++; $display("FAIL single_latency%0d: res_val %b want %b", m, bus.res_val, (m == 3)); end
    end
    n_cmp++; if (bus.result_re !== 23 || bus.result_im !== 14) begin n_err++; $display("FAIL single_value: got %0d %0dj want 23 14j", bus.result_re, bus.result_im); end
    n_cmp++; if (bus.res_count !== 1) begin n_err++; $display("FAIL single_count: got %0d want 1", bus.res_count); end
    @(negedge clk);
    n_cmp++; if (bus.res_count !== 0 || bus.res_val !== 1'b0) begin n_err++; $display("FAIL single_empty: count %0d val %b want 0 0", bus.res_count, bus.res_val); end
    drain("single");
  endtask

  task automatic test_corner();
    bus.res_ready = 1'b1;
    send_op(-128, -128, -128, -128, 1'b0);
    send_op(-128, 127, -128, -128, 1'b0);
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.result_re !== 0 || bus.result_im !== 32768) begin n_err++; $display("FAIL corner_min: got %0d %0dj want 0 32768j", bus.result_re, bus.result_im); end
    @(negedge clk);
    n_cmp++; if (bus.result_re !== 32640 || bus.result_im !== 128) begin n_err++; $display("FAIL corner_mixed: got %0d %0dj want 32640 128j", bus.result_re, bus.result_im); end
    drain("corner");
  endtask

  task automatic test_backpressure();
    int acc;
    acc = 0;
    bus.res_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      set_op(int'($urandom), int'($urandom), int'($urandom), int'($urandom));
      bus.op_val = 1'b1;
      @(negedge clk);
      if (bus.op_ready) acc++;
      @(posedge clk); #1;
    end
    bus.op_val = 1'b0;
    n_cmp++; if (acc != 4) begin n_err++; $display("FAIL bp_accepted: got %0d want 4", acc); end
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.op_ready !== 1'b0) begin n_err++; $display("FAIL bp_op_ready_full: got %b want 0", bus.op_ready); end
    n_cmp++; if (bus.res_count !== 4) begin n_err++; $display("FAIL bp_count: got %0d want 4", bus.res_count); end
    @(posedge clk); #1;
    bus.res_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.op_ready !== 1'b0) begin n_err++; $display("FAIL bp_before_pop: op_ready %b want 0", bus.op_ready); end
    @(negedge clk);
    n_cmp++; if (bus.op_ready !== 1'b1) begin n_err++; $display("FAIL bp_after_pop: op_ready %b want 1", bus.op_ready); end
    drain("bp");
  endtask

  task automatic test_streaming();
    int base;
    base = n_res;
    bus.res_ready = 1'($urandom_range(1));
    for (int i = 0; i < 20; i++) begin
      send_op(int'($urandom), int'($urandom), int'($urandom), int'($urandom), 1'b1);
    end
    drain("stream");
    n_cmp++; if (n_res - base != 20) begin n_err++; $display("FAIL stream_count: got %0d results want 20", n_res - base); end
  endtask

  task automatic test_reset_midop();
    int tmo, base;
    bus.res_ready = 1'b0;
    send_op(7, -3, 2, 9, 1'b0);
    send_op(-50, 60, 70, -80, 1'b0);
    tmo = 0;
    while (bus.res_count != 2 && tmo < 20) begin @(negedge clk); tmo++; end
    n_cmp++; if (bus.res_count !== 2) begin n_err++; $display("FAIL rst_fill: res_count %0d want 2", bus.res_count); end
    @(posedge clk); #1;
    send_op(11, 12, 13, 14, 1'b0);
    send_op(-1, -2, -3, -4, 1'b0);
    sw_rst = 1'b1;
    @(posedge clk); #1;
    sw_rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.op_ready !== 1'b0 || bus.res_val !== 1'b0 || bus.res_count !== 0) begin
      n_err++; $display("FAIL rst_midop_state: ready %b val %b count %0d want 0 0 0", bus.op_ready, bus.res_val, bus.res_count);
    end
    base = n_res;
    repeat (8) @(negedge clk);
    n_cmp++; if (bus.res_val !== 1'b0 || bus.res_count !== 0) begin n_err++; $display("FAIL rst_stale: val %b count %0d want 0 0", bus.res_val, bus.res_count); end
    @(posedge clk); #1;
    bus.res_ready = 1'b1;
    send_op(1, 1, 1, -1, 1'b0);
    tmo = 0;
    @(negedge clk);
    while (!bus.res_val && tmo < 20) begin @(negedge clk); tmo++; end
    n_cmp++; if (bus.res_val !== 1'b1 || bus.result_re !== 2 || bus.result_im !== 0) begin
      n_err++; $display("FAIL rst_next_op: val %b got %0d %0dj want 1 2 0j", bus.res_val, bus.result_re, bus.result_im);
    end
    drain("rst");
    n_cmp++; if (n_res - base != 1) begin n_err++; $display("FAIL rst_result_count: got %0d want 1", n_res - base); end
  endtask

`ifdef COMPLEX_CONJ_EN
  task automatic test_conj();
    bus.res_ready = 1'b1;
    bus.op_conj = 1'b1;
    send_op(3, 4, 5, -2, 1'b0);
    repeat (4) @(negedge clk);
    n_cmp++; if (bus.result_re !== 7 || bus.result_im !== 26) begin n_err++; $display("FAIL conj_value: got %0d %0dj want 7 26j", bus.result_re, bus.result_im); end
    for (int i = 0; i < 6; i++) begin
      bus.op_conj = 1'(i % 2);
      send_op(int'($urandom), int'($urandom), int'($urandom), int'($urandom), 1'b0);
    end
    bus.op_conj = 1'b0;
    drain("conj");
  endtask
`endif

  initial begin
    bus.op_val = 1'b0;
    bus.res_ready = 1'b0;
    set_op(0, 0, 0, 0);
`ifdef COMPLEX_CONJ_EN
    bus.op_conj = 1'b0;
`endif
    test_reset();
    test_single();
    test_corner();
    test_backpressure();
    test_streaming();
    test_reset_midop();
`ifdef COMPLEX_CONJ_EN
    test_conj();
`endif
    n_cmp++;
    if (sb.size() != 0) begin n_err++; $display("FAIL final_leftover: %0d results outstanding want 0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
